// File: rtl/regbank_pkg.sv
// ---------------------------------------------------------------------------
// regbank_pkg
// Shared defaults and helpers for the scoreboarded register bank.
//   DEF_WIDTH / DEF_DEPTH / DEF_NUM_RD / DEF_MAX_PEND : default parameters
//   reg_addr_t : register address type for the default depth
//   pend_w()   : bit width needed to hold a pend count of 0..MAX_PEND
// ---------------------------------------------------------------------------
package regbank_pkg;

  localparam int DEF_WIDTH    = 64;
  localparam int DEF_DEPTH    = 32;
  localparam int DEF_NUM_RD   = 2;
  localparam int DEF_MAX_PEND = 3;

  typedef logic [$clog2(DEF_DEPTH)-1:0] reg_addr_t;

  function automatic int pend_w(input int maxPend);
    return $clog2(maxPend + 1);
  endfunction

endpackage

// File: rtl/regbank_sb_cnt.sv
// ---------------------------------------------------------------------------
// regbank_sb_cnt
// One outstanding-write counter for a single register.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset, clears the count
//   i_inc   : an issue targets this register this cycle
//   i_dec   : a writeback targets this register this cycle
//   o_full  : count == MAX_PEND (pre-edge)
//   o_nz    : count != 0 (pre-edge)
//   o_last  : only with REGBANK_SB_BYPASS_EN; the count is 1 and this
//             cycle's writeback retires it to 0
// ---------------------------------------------------------------------------
module regbank_sb_cnt
  import regbank_pkg::*;
#(
  parameter int MAX_PEND = DEF_MAX_PEND,
  localparam int PW      = pend_w(MAX_PEND)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_full,
`ifdef REGBANK_SB_BYPASS_EN
  output logic o_last,
`endif
  output logic o_nz
);

  logic [PW-1:0] r_cnt;
  logic [PW-1:0] w_delta;
  logic          w_decOk;
  logic          w_incOk;

  assign o_full = (r_cnt == PW'(MAX_PEND));
  assign o_nz   = (r_cnt != '0);

  // A writeback with nothing outstanding must not underflow the count.
  // An issue at full is still taken when a writeback frees a slot in the
  // same cycle, so the count simply holds at MAX_PEND.
  assign w_decOk = i_dec & o_nz;
  assign w_incOk = i_inc & (~o_full | w_decOk);

`ifdef REGBANK_SB_BYPASS_EN
  assign o_last = (r_cnt == PW'(1)) & w_decOk & ~w_incOk;
`endif

  // Delta of +1 / 0 / -1 feeding one adder; -1 is all ones.
  always_comb begin
    w_delta = '0;
    if (w_incOk && !w_decOk) begin
      w_delta = PW'(1);
    end else if (w_decOk && !w_incOk) begin
      w_delta = '1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + w_delta;
    end
  end

endmodule

// File: rtl/regbank_sb.sv
// ---------------------------------------------------------------------------
// regbank_sb
// Multi-port register bank with register 0 hardwired to zero and a
// per-register outstanding-write scoreboard.
//   i_clk        : clock, rising edge
//   i_rst_n      : asynchronous active-low reset
//   i_ra         : NUM_RD read addresses, port i at slice i
//   o_rd         : NUM_RD read data words, port i at slice i
//   o_rd_hazard  : per port, the read register has outstanding writes
//   i_wen/i_wa/i_wd : writeback enable, address, data
//   i_iss_en     : issue of an instruction writing i_iss_rd
//   i_iss_rd     : issued destination register
//   o_iss_full   : pend count of i_iss_rd is at MAX_PEND
// Build option: define REGBANK_SB_BYPASS_EN for same-cycle write-through
// on the read ports (data and hazard). Without it reads see the pre-edge
// register contents and pend counts.
// ---------------------------------------------------------------------------
module regbank_sb
  import regbank_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int MAX_PEND = DEF_MAX_PEND,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NUM_RD*AW-1:0]    i_ra,
  output logic [NUM_RD*WIDTH-1:0] o_rd,
  output logic [NUM_RD-1:0]       o_rd_hazard,
  input  logic                    i_wen,
  input  logic [AW-1:0]           i_wa,
  input  logic [WIDTH-1:0]        i_wd,
  input  logic                    i_iss_en,
  input  logic [AW-1:0]           i_iss_rd,
  output logic                    o_iss_full
);

  logic [WIDTH-1:0] r_regFile [DEPTH];
  logic [DEPTH-1:0] w_full;
  logic [DEPTH-1:0] w_nz;
`ifdef REGBANK_SB_BYPASS_EN
  logic [DEPTH-1:0] w_last;
`endif

  // Entry 0 is never written after reset, so it always holds zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_regFile[k] <= '0;
      end
    end else if (i_wen && (i_wa != '0)) begin
      r_regFile[i_wa] <= i_wd;
    end
  end

  // Register 0 is never tracked.
  assign w_full[0] = 1'b0;
  assign w_nz[0]   = 1'b0;
`ifdef REGBANK_SB_BYPASS_EN
  assign w_last[0] = 1'b0;
`endif

  for (genvar g = 1; g < DEPTH; g++) begin : g_cnt
    regbank_sb_cnt #(
      .MAX_PEND (MAX_PEND)
    ) u_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_inc   (i_iss_en && (i_iss_rd == AW'(g))),
      .i_dec   (i_wen && (i_wa == AW'(g))),
      .o_full  (w_full[g]),
`ifdef REGBANK_SB_BYPASS_EN
      .o_last  (w_last[g]),
`endif
      .o_nz    (w_nz[g])
    );
  end

  assign o_iss_full = w_full[i_iss_rd];

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0] w_ra;
    assign w_ra = i_ra[p*AW +: AW];
`ifdef REGBANK_SB_BYPASS_EN
    logic w_wrHit;
    assign w_wrHit = i_wen && (i_wa == w_ra) && (w_ra != '0);
    assign o_rd[p*WIDTH +: WIDTH] = (w_ra == '0) ? '0 :
                                    w_wrHit      ? i_wd : r_regFile[w_ra];
    // Hazard drops early only when this write retires the last pending one.
    assign o_rd_hazard[p] = w_nz[w_ra] & ~w_last[w_ra];
`else
    assign o_rd[p*WIDTH +: WIDTH] = (w_ra == '0) ? '0 : r_regFile[w_ra];
    assign o_rd_hazard[p] = w_nz[w_ra];
`endif
  end

endmodule
